// File: rtl/object_table_scanner.sv
// End-of-frame sweep over connected-component labels: looks up each label's stats,
// drops objects under the area threshold and streams the survivors over valid/ready.
module object_table_scanner #(
  parameter int LABEL_W    = 8,
  parameter int LOC_W      = 11,
  parameter int LOOKUP_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] num_labels,
  input  logic [LOC_W-1:0]   min_area,
  output logic [LABEL_W-1:0] obj_id,
  input  logic [LOC_W-1:0]   obj_area,
  input  logic [LOC_W-1:0]   obj_x,
  input  logic [LOC_W-1:0]   obj_y,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [LABEL_W-1:0] rec_id,
  output logic [LOC_W-1:0]   rec_area,
  output logic [LOC_W-1:0]   rec_x,
  output logic [LOC_W-1:0]   rec_y,
  output logic [LABEL_W-1:0] rec_count,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(LOOKUP_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LABEL_W-1:0] obj_id_q, obj_id_d;
  logic [LABEL_W-1:0] n_q, n_d;
  logic [LOC_W-1:0]   min_area_q, min_area_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               rec_valid_q, rec_valid_d;
  logic [LABEL_W-1:0] rec_id_q, rec_id_d;
  logic [LOC_W-1:0]   rec_area_q, rec_area_d;
  logic [LOC_W-1:0]   rec_x_q, rec_x_d;
  logic [LOC_W-1:0]   rec_y_q, rec_y_d;
  logic [LABEL_W-1:0] rec_count_q, rec_count_d;

  logic qualifies;
  logic last_label;

  assign qualifies  = (obj_area != '0) && (obj_area >= min_area_q);
  // Compared before incrementing so a full 8-bit label range never wraps obj_id.
  assign last_label = (obj_id_q == n_q);

  always_comb begin
    state_d     = state_q;
    obj_id_d    = obj_id_q;
    n_d         = n_q;
    min_area_d  = min_area_q;
    wait_d      = wait_q;
    rec_valid_d = rec_valid_q;
    rec_id_d    = rec_id_q;
    rec_area_d  = rec_area_q;
    rec_x_d     = rec_x_q;
    rec_y_d     = rec_y_q;
    rec_count_d = rec_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d         = num_labels;
          min_area_d  = min_area;
          rec_count_d = '0;
          if (num_labels != '0) begin
            obj_id_d = LABEL_W'(1);
            wait_d   = '0;
            state_d  = LOOKUP;
          end else begin
            state_d = DONE;
          end
        end
      end

      LOOKUP: begin
        wait_d = wait_q + CNT_W'(1);
        if (wait_q == SAMPLE_AT) begin
          if (qualifies) begin
            rec_id_d    = obj_id_q;
            rec_area_d  = obj_area;
            rec_x_d     = obj_x;
            rec_y_d     = obj_y;
            rec_valid_d = 1'b1;
            state_d     = EMIT;
          end else if (last_label) begin
            state_d = DONE;
          end else begin
            obj_id_d = obj_id_q + LABEL_W'(1);
            wait_d   = '0;
          end
        end
      end

      EMIT: begin
        if (rec_ready) begin
          rec_valid_d = 1'b0;
          rec_count_d = rec_count_q + LABEL_W'(1);
          if (last_label) begin
            state_d = DONE;
          end else begin
            obj_id_d = obj_id_q + LABEL_W'(1);
            wait_d   = '0;
            state_d  = LOOKUP;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      obj_id_q    <= '0;
      n_q         <= '0;
      min_area_q  <= '0;
      wait_q      <= '0;
      rec_valid_q <= 1'b0;
      rec_id_q    <= '0;
      rec_area_q  <= '0;
      rec_x_q     <= '0;
      rec_y_q     <= '0;
      rec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      obj_id_q    <= obj_id_d;
      n_q         <= n_d;
      min_area_q  <= min_area_d;
      wait_q      <= wait_d;
      rec_valid_q <= rec_valid_d;
      rec_id_q    <= rec_id_d;
      rec_area_q  <= rec_area_d;
      rec_x_q     <= rec_x_d;
      rec_y_q     <= rec_y_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign obj_id    = obj_id_q;
  assign rec_valid = rec_valid_q;
  assign rec_id    = rec_id_q;
  assign rec_area  = rec_area_q;
  assign rec_x     = rec_x_q;
  assign rec_y     = rec_y_q;
  assign rec_count = rec_count_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
